// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: digit count and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit hex display driver with frame-coherent snapshot
// and optional leading-zero blanking; outputs are registered.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [2:0]    idx;
   logic [31:0]   snapshot;
   logic          tick;

   logic [3:0]    nibble;
   logic [6:0]    seg_hex;
   logic [7:0]    lz_run;
   logic          run;
   logic          blank;
   logic [7:0]    an_nxt;
   logic [6:0]    seg_nxt;

   logic [7:0]    an_p1;
   logic [6:0]    seg_p1;
   logic          dp_p1;

   assign tick = (prescaler == DIV_MAX);

   // Stage 0: slot timing, digit index and per-frame snapshot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         idx       <= '0;
         snapshot  <= '0;
      end else begin
         if (tick) begin
            prescaler <= '0;
            idx       <= idx + 3'd1;
            if (idx == 3'd7)
               snapshot <= data_in;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   assign nibble = snapshot[{idx, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble (nibble),
      .seg    (seg_hex)
   );

   // lz_run[i] is set when nibbles i..7 of the snapshot are all zero
   always_comb begin
      lz_run = '0;
      run    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run       = run & (snapshot[4*i +: 4] == 4'h0);
         lz_run[i] = run;
      end
   end

   assign blank = blank_lz && (idx != 3'd0) && lz_run[idx];

   always_comb begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = seg_hex;
      if (blank) begin
         an_nxt  = 8'hFF;
         seg_nxt = SEG_OFF;
      end
   end

   // Stage 1: registered display drive
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_p1  <= 8'hFF;
         seg_p1 <= SEG_OFF;
         dp_p1  <= 1'b1;
      end else begin
         an_p1  <= an_nxt;
         seg_p1 <= seg_nxt;
         dp_p1  <= 1'b1;
      end
   end

   assign an  = an_p1;
   assign seg = seg_p1;
   assign dp  = dp_p1;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CLK_DIV=4: slot k of frame f is visible
// from the (32f+4k+1)th clk edge after reset release through edge 32f+4k+4.
module tb_seg7_scan;

   logic        clk;
   logic        reset;
   logic [31:0] data_in;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] PA = 7'b0001000;
   localparam logic [6:0] PF = 7'b0001110;
   localparam logic [6:0] POFF = 7'h7F;

   seg7_scan #(.CLK_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic goto_edge(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic slot(input string tag, input int n, input logic [7:0] an_e, input logic [6:0] seg_e);
      goto_edge(n);
      check({tag, ".an"}, {24'd0, an}, {24'd0, an_e});
      check({tag, ".seg"}, {25'd0, seg}, {25'd0, seg_e});
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic idle_check(input string tag);
      check({tag, ".an"}, {24'd0, an}, 32'hFF);
      check({tag, ".seg"}, {25'd0, seg}, 32'h7F);
      check({tag, ".dp"}, {31'd0, dp}, 32'h1);
   endtask

   initial begin
      reset    = 1'b1;
      data_in  = 32'h12345678;
      blank_lz = 1'b0;
      #3;
      idle_check("por");

      // Basic scan, first frame shows snapshot 0
      release_reset();
      slot("f0s0_first", 1, 8'hFE, P0);
      slot("f0s0_end", 4, 8'hFE, P0);
      slot("f0s1", 5, 8'hFD, P0);
      slot("f0s7", 29, 8'h7F, P0);
      slot("f1s0", 33, 8'hFE, P8);
      slot("f1s0_end", 36, 8'hFE, P8);
      slot("f1s1", 37, 8'hFD, P7);
      slot("f1s7", 61, 8'h7F, P1);
      slot("f1s7_end", 64, 8'h7F, P1);
      check("dp_run", {31'd0, dp}, 32'h1);

      // Change data during slot 3 of frame 2: rest of frame must not tear
      goto_edge(78);
      data_in = 32'hFFFFFFFF;
      slot("tear_s4", 81, 8'hEF, P4);
      slot("tear_s5", 85, 8'hDF, P3);
      slot("tear_s6", 89, 8'hBF, P2);
      slot("tear_s7", 93, 8'h7F, P1);
      slot("newf_s0", 97, 8'hFE, PF);
      slot("newf_s7", 125, 8'h7F, PF);

      // Async reset mid-cycle
      #2;
      reset = 1'b1;
      #1;
      idle_check("rst_async");

      // Leading-zero blanking
      data_in  = 32'h00000A05;
      blank_lz = 1'b1;
      release_reset();
      slot("bl_f0s0", 1, 8'hFE, P0);
      slot("bl_f0s1", 5, 8'hFF, POFF);
      slot("bl_f0s7", 29, 8'hFF, POFF);
      slot("bl_s0", 33, 8'hFE, P5);
      slot("bl_s1", 37, 8'hFD, P0);
      slot("bl_s2", 41, 8'hFB, PA);
      slot("bl_s3", 45, 8'hFF, POFF);
      slot("bl_s5", 53, 8'hFF, POFF);
      blank_lz = 1'b0;
      slot("bl_live_s6", 57, 8'hBF, P0);
      slot("bl_live_s7", 61, 8'h7F, P0);

      // Reset pulse during slot 5 of frame 2
      goto_edge(86);
      #2;
      reset = 1'b1;
      #1;
      idle_check("rst_s5");
      @(posedge clk);
      #1;
      idle_check("rst_s5_held");
      release_reset();
      slot("rr_s0", 1, 8'hFE, P0);
      slot("rr_s0_end", 4, 8'hFE, P0);
      slot("rr_s1", 5, 8'hFD, P0);
      slot("rr_s7", 29, 8'h7F, P0);
      slot("rr_f1s0", 33, 8'hFE, P5);

      // Value zero with blanking shows a single 0
      reset = 1'b1;
      #1;
      data_in  = 32'h0;
      blank_lz = 1'b1;
      release_reset();
      slot("z_s0", 33, 8'hFE, P0);
      slot("z_s1", 37, 8'hFF, POFF);
      slot("z_s7", 61, 8'hFF, POFF);
      check("z_dp", {31'd0, dp}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_in  input  32  value from the output-device register, 8 hex nibbles, nibble i = data_in[4i+3:4i].
REQ-005 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-006 SHALL have port an  output  8  digit enables, active-low, an[i] = digit i.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-009 SHALL hold a prescaler counting 0..CLK_DIV-1, then wrapping to 0; tick = (prescaler == CLK_DIV-1).
REQ-010 SHALL hold a 3-bit digit index, +1 on each tick, wrapping 7 -> 0.
REQ-011 SHALL hold a 32-bit snapshot loaded from data_in only on a tick with digit index 7, coincident with the wrap to 0.
REQ-012 SHALL leave data_in changes within a frame invisible until the next snapshot load, so no frame is torn.
REQ-013 SHALL register an/seg/dp: they reflect the digit index and snapshot of the previous clk, 1-cycle latency.
REQ-014 SHALL drive exactly one an bit low per slot, an[idx]=0, unless that digit is blanked (REQ-017).
REQ-015 SHALL drive seg with the hex pattern of nibble idx of the snapshot: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-016 SHALL drive dp = 1 (off) at all times.
REQ-017 SHALL, when blank_lz=1, blank digit i (i>0) if snapshot nibbles i..7 are all zero: an=8'hFF, seg=7'h7F during that slot.
REQ-018 SHALL never blank digit 0, so value 0 displays as a single "0".
REQ-019 SHALL sample blank_lz combinationally each cycle; it is not snapshotted.

Reset
REQ-020 SHALL, while reset=1, force prescaler=0, digit index=0, snapshot=0, an=8'hFF, seg=7'h7F, dp=1, immediately and regardless of clk.
REQ-021 SHALL, on the first clk after reset release, output digit 0 of snapshot 0: an=8'hFE, seg=1000000.
REQ-022 SHALL on reset mid-frame abandon the frame; scanning restarts at digit 0 with a full CLK_DIV slot.

Structure
REQ-023 SHALL place the 16 segment patterns, SEG_OFF (7'h7F) and NUM_DIGITS (8) in shared package seg7_pkg.
REQ-024 SHALL implement the nibble-to-segment table as combinational sub-module seg7_decode (4-bit in, 7-bit out), instantiated once.
REQ-025 SHALL size the prescaler as $clog2(CLK_DIV) bits.

Verification (CLK_DIV=4 throughout)
REQ-026 SHALL cover: reset asserted mid-cycle -> an=FF, seg=7F, dp=1 without waiting for a clk edge.
REQ-027 SHALL cover: data_in=32'h12345678, blank_lz=0, after first snapshot load (32 clk from release) -> slot 0 an=FE seg=0000000, slot 7 an=7F seg=1111001, each slot 4 clk long.
REQ-028 SHALL cover: during slot 3, data_in changes 32'h12345678 -> 32'hFFFFFFFF -> slots 4..7 still show 4,3,2,1; next frame shows F in all slots (seg=0001110).
REQ-029 SHALL cover: blank_lz=1, data_in=32'h00000A05 -> slots 0,1,2 show 5,0,A; slots 3..7 an=FF, seg=7F.
REQ-030 SHALL cover: blank_lz=1, data_in=0 -> slot 0 an=FE seg=1000000; all other slots an=FF.
REQ-031 SHALL cover: reset pulse during slot 5 -> outputs idle during reset; after release an=FE for 4 clk, then FD; snapshot=0 until the next frame wrap.
